// File: rtl/icesoc_pkg.sv
// icesoc_pkg: shared FSM encoding and default constants for the OBI-to-Wishbone bridge
package icesoc_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;
   localparam logic [31:0] DEF_ERR_DATA     = 32'hDEAD_BEEF;
   localparam logic [31:0] DEF_WB_BASE_ADDR = 32'h3000_0000;
endpackage

// File: rtl/wb_timeout_ctr.sv
// wb_timeout_ctr: Wishbone wait counter, flags expiry on the cycle it would reach TIMEOUT_CYCLES
module wb_timeout_ctr #(
   parameter int TIMEOUT_CYCLES = 255,
   localparam int CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8
) (
   input  logic clk_i,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   logic [CW-1:0] cnt;
   always_ff @(posedge clk_i) begin
      if (reset || clear) cnt <= '0;
      else if (enable) cnt <= cnt + CW'(1);
   end
   assign expired = enable && (cnt == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/obi_wb_master_bridge.sv
// obi_wb_master_bridge: req/gnt/rvalid slave port re-issued as a classic Wishbone master cycle; WB_TIMEOUT_EN adds a bus timeout
module obi_wb_master_bridge
   import icesoc_pkg::*;
#(
   parameter int          SLAVE_ADDR_WIDTH = 10,
   parameter logic [31:0] WB_BASE_ADDR     = DEF_WB_BASE_ADDR,
   parameter int          TIMEOUT_CYCLES   = 255,
   parameter logic [31:0] ERR_DATA         = DEF_ERR_DATA
) (
   input  logic                        clk_i,
   input  logic                        reset,
   input  logic                        data_req_i,
   input  logic [SLAVE_ADDR_WIDTH-1:0] data_addr_i,
   input  logic                        data_we_i,
   input  logic [3:0]                  data_be_i,
   input  logic [31:0]                 data_wdata_i,
   output logic                        data_gnt_o,
   output logic                        data_rvalid_o,
   output logic [31:0]                 data_rdata_o,
   output logic                        wbm_cyc_o,
   output logic                        wbm_stb_o,
   output logic                        wbm_we_o,
   output logic [3:0]                  wbm_sel_o,
   output logic [31:0]                 wbm_adr_o,
   output logic [31:0]                 wbm_dat_o,
   input  logic [31:0]                 wbm_dat_i,
   input  logic                        wbm_ack_i,
   input  logic                        wbm_err_i,
   output logic                        timeout_o
);
   state_t state;
   logic   expired;
`ifdef WB_TIMEOUT_EN
   wb_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk_i   (clk_i),
      .reset   (reset),
      .clear   (state != BUS),
      .enable  (state == BUS && !wbm_ack_i && !wbm_err_i),
      .expired (expired)
   );
`else
   assign expired = 1'b0;
`endif
   assign data_gnt_o = !reset && state == IDLE && data_req_i;
   assign wbm_stb_o  = wbm_cyc_o;
   always_ff @(posedge clk_i) begin
      if (reset) begin
         state         <= IDLE;
         wbm_cyc_o     <= 1'b0;
         wbm_we_o      <= 1'b0;
         wbm_sel_o     <= '0;
         wbm_adr_o     <= '0;
         wbm_dat_o     <= '0;
         data_rvalid_o <= 1'b0;
         data_rdata_o  <= '0;
         timeout_o     <= 1'b0;
      end else begin
         case (state)
            IDLE: if (data_req_i) begin
               state     <= BUS;
               wbm_cyc_o <= 1'b1;
               wbm_we_o  <= data_we_i;
               wbm_sel_o <= data_be_i;
               wbm_dat_o <= data_wdata_i;
               wbm_adr_o <= WB_BASE_ADDR + 32'({data_addr_i, 2'b00});
            end
            BUS: if (wbm_ack_i || wbm_err_i || expired) begin
               state         <= RESP;
               wbm_cyc_o     <= 1'b0;
               data_rvalid_o <= 1'b1;
               data_rdata_o  <= wbm_ack_i ? (wbm_we_o ? 32'h0 : wbm_dat_i) : ERR_DATA;
               if (!wbm_ack_i) timeout_o <= 1'b1;
            end
            default: begin
               state         <= IDLE;
               data_rvalid_o <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_obi_wb_master_bridge.sv
// tb_obi_wb_master_bridge: directed scoreboard bench for obi_wb_master_bridge
module tb_obi_wb_master_bridge;
   localparam logic [31:0] BASE = 32'h3000_0000;
   localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
   logic        clk = 1'b0, reset = 1'b1;
   logic        req = 1'b0, we = 1'b0, ack = 1'b0, err = 1'b0;
   logic [9:0]  addr = '0;
   logic [3:0]  be = '0;
   logic [31:0] wdata = '0, wb_din = '0;
   logic        gnt, rvalid, cyc, stb, wbm_we, tmo;
   logic [3:0]  sel;
   logic [31:0] rdata, adr, wb_dout;
   int          total = 0, bad = 0, rv_cnt = 0;
   logic [31:0] exp_q[$];

   obi_wb_master_bridge #(.TIMEOUT_CYCLES(8)) dut (
      .clk_i(clk), .reset(reset), .data_req_i(req), .data_addr_i(addr), .data_we_i(we),
      .data_be_i(be), .data_wdata_i(wdata), .data_gnt_o(gnt), .data_rvalid_o(rvalid),
      .data_rdata_o(rdata), .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(wbm_we),
      .wbm_sel_o(sel), .wbm_adr_o(adr), .wbm_dat_o(wb_dout), .wbm_dat_i(wb_din),
      .wbm_ack_i(ack), .wbm_err_i(err), .timeout_o(tmo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) begin
      #1;
      if (rvalid === 1'b1) begin
         rv_cnt++;
         if (exp_q.size() == 0) check("rvalid_unexpected", 32'd1, 32'd0);
         else check("rdata", rdata, exp_q.pop_front());
      end
   end

   // Entry/exit: just after a rising edge with the bridge idle.
   task automatic xfer(input logic [9:0] a, input logic w, input logic [3:0] b, input logic [31:0] wd,
                       input int wait_n, input logic give_ack, input logic give_err, input logic [31:0] rd);
      req = 1'b1; addr = a; we = w; be = b; wdata = wd;
      #1;
      check("gnt", {31'd0, gnt}, 32'd1);
      exp_q.push_back(w && give_ack ? 32'h0 : (give_ack ? rd : ERRD));
      tick();
      req = 1'b0;
      check("cyc_start", {31'd0, cyc}, 32'd1);
      check("stb_start", {31'd0, stb}, 32'd1);
      check("adr", adr, BASE + {20'd0, a, 2'b00});
      check("we", {31'd0, wbm_we}, {31'd0, w});
      check("sel", {28'd0, sel}, {28'd0, b});
      check("dat_o", wb_dout, wd);
      for (int i = 0; i < wait_n; i++) begin
         tick();
         check("cyc_wait", {31'd0, cyc}, 32'd1);
      end
      ack = give_ack; err = give_err; wb_din = rd;
      tick();
      ack = 1'b0; err = 1'b0;
      check("cyc_end", {31'd0, cyc}, 32'd0);
      check("rvalid_pulse", {31'd0, rvalid}, 32'd1);
      check("gnt_resp", {31'd0, gnt}, 32'd0);
      tick();
      check("rvalid_drop", {31'd0, rvalid}, 32'd0);
   endtask

   initial begin
      int gn, rises, rv0, second_at;
      logic prev_cyc;
      req = 1'b1;
      tick(); tick();
      check("rst_gnt", {31'd0, gnt}, 32'd0);
      check("rst_cyc", {31'd0, cyc}, 32'd0);
      check("rst_rvalid", {31'd0, rvalid}, 32'd0);
      check("rst_adr", adr, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_tmo", {31'd0, tmo}, 32'd0);
      req = 1'b0; reset = 1'b0;
      tick();
      xfer(10'h004, 1'b0, 4'hF, 32'h0, 2, 1'b1, 1'b0, 32'h1234_5678);
      xfer(10'h011, 1'b1, 4'b0011, 32'hA5A5_0F0F, 0, 1'b1, 1'b0, 32'h5555_5555);
      // request held high across two transactions
      gn = 0; rises = 0; rv0 = rv_cnt; second_at = -1; prev_cyc = 1'b0;
      req = 1'b1; we = 1'b0; addr = 10'h020; be = 4'hF; wb_din = 32'hCAFE_0001;
      for (int i = 0; i < 8; i++) begin
         ack = cyc;
         if (cyc && !prev_cyc) rises++;
         prev_cyc = cyc;
         #1;
         if (i == 1 || i == 2) check("gnt_busy", {31'd0, gnt}, 32'd0);
         if (gnt) begin
            gn++;
            exp_q.push_back(32'hCAFE_0001);
            if (gn == 2) second_at = i;
         end
         tick();
         if (gn == 2) req = 1'b0;
      end
      ack = 1'b0;
      check("held_gnts", gn, 2);
      check("held_second_gnt", second_at, 3);
      check("held_cycles", rises, 2);
      check("held_rvalids", rv_cnt - rv0, 2);
      xfer(10'h008, 1'b1, 4'b0000, 32'h0BAD_F00D, 1, 1'b1, 1'b0, 32'h0);
      xfer(10'h030, 1'b0, 4'hF, 32'h0, 0, 1'b1, 1'b1, 32'h1111_2222);
      check("ack_err_tmo", {31'd0, tmo}, 32'd0);
      xfer(10'h031, 1'b0, 4'hF, 32'h0, 1, 1'b0, 1'b1, 32'h3333_4444);
      check("err_tmo", {31'd0, tmo}, 32'd1);
      xfer(10'h032, 1'b0, 4'hF, 32'h0, 0, 1'b1, 1'b0, 32'h7777_8888);
      check("tmo_sticky", {31'd0, tmo}, 32'd1);
      // reset in the second BUS cycle discards the request
      req = 1'b1; we = 1'b1; addr = 10'h3FF; be = 4'hF; wdata = 32'hFFFF_0000;
      #1;
      check("mid_gnt", {31'd0, gnt}, 32'd1);
      tick();
      req = 1'b0;
      check("mid_cyc1", {31'd0, cyc}, 32'd1);
      tick();
      reset = 1'b1;
      tick();
      check("mid_cyc", {31'd0, cyc}, 32'd0);
      check("mid_stb", {31'd0, stb}, 32'd0);
      check("mid_rvalid", {31'd0, rvalid}, 32'd0);
      check("mid_we", {31'd0, wbm_we}, 32'd0);
      check("mid_sel", {28'd0, sel}, 32'd0);
      check("mid_adr", adr, 32'd0);
      check("mid_dat", wb_dout, 32'd0);
      check("mid_rdata", rdata, 32'd0);
      check("mid_tmo", {31'd0, tmo}, 32'd0);
      reset = 1'b0;
      tick();
      check("mid_no_rvalid", {31'd0, rvalid}, 32'd0);
      xfer(10'h3FF, 1'b0, 4'hF, 32'h0, 0, 1'b1, 1'b0, 32'h9ABC_DEF0);
`ifdef WB_TIMEOUT_EN
      req = 1'b1; we = 1'b0; addr = 10'h005; be = 4'hF;
      #1;
      check("to_gnt", {31'd0, gnt}, 32'd1);
      exp_q.push_back(ERRD);
      tick();
      req = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         check("to_cyc_high", {31'd0, cyc}, 32'd1);
         tick();
      end
      check("to_cyc_drop", {31'd0, cyc}, 32'd0);
      check("to_rvalid", {31'd0, rvalid}, 32'd1);
      check("to_tmo", {31'd0, tmo}, 32'd1);
      tick(); tick();
      check("to_tmo_sticky", {31'd0, tmo}, 32'd1);
`endif
      tick();
      check("queue_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
